// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared constants and helpers for the input conditioner
package input_cond_pkg;

    // Long-press FSM states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;

    // Bits needed to hold values 0..n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_cond_channel.sv
// rtl/input_cond_channel.sv - one channel: sync, debounce, edge pulses, long-press and auto-repeat
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in            raw asynchronous input
//   repeat_en     auto-repeat enable, sampled every cycle
//   level         debounced, polarity-corrected level
//   rise, fall    one-cycle pulses coincident with the new level
//   long_press    one-cycle pulse after HOLD_CYCLES of level=1
//   repeat_pulse  one-cycle pulse every REPEAT_CYCLES after long_press
module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   HOLD_CYCLES     = 50_000_000,
    parameter int   REPEAT_CYCLES   = 10_000_000,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic repeat_en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = cnt_w((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          db_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [1:0]             state;
    logic                   s;
    logic                   flip;

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;
    // Level is about to toggle on this edge; direction is given by the current level
    assign flip = (s != level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            db_cnt       <= '0;
            level        <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            hold_cnt     <= '0;
            state        <= IDLE;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], in};
            rise         <= 1'b0;
            fall         <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;

            if (s == level) begin
                db_cnt <= '0;
            end else if (flip) begin
                level  <= ~level;
                db_cnt <= '0;
                rise   <= ~level;
                fall   <= level;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            // A falling level overrides whatever the FSM would do this edge,
            // so a same-edge long_press or repeat is dropped.
            if (flip && level) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (flip) begin
                            state    <= PRESSED;
                            hold_cnt <= '0;
                        end
                    end
                    PRESSED: begin
                        if (hold_cnt == HOLD_LAST) begin
                            long_press <= 1'b1;
                            state      <= HELD;
                            hold_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    HELD: begin
                        // Counter keeps running with repeat disabled so enabling
                        // mid-hold stays in phase with the original press.
                        if (hold_cnt == REP_LAST) begin
                            hold_cnt     <= '0;
                            repeat_pulse <= repeat_en;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel button/switch conditioner top
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in            raw asynchronous inputs, one bit per channel
//   repeat_en     per-channel auto-repeat enable
//   level         debounced, polarity-corrected levels
//   rise, fall    per-channel edge pulses
//   long_press    per-channel long-press pulse
//   repeat_pulse  per-channel auto-repeat pulse
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter int                  HOLD_CYCLES     = 50_000_000,
    parameter int                  REPEAT_CYCLES   = 10_000_000,
    parameter logic [CHANNELS-1:0] INVERT          = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] repeat_pulse
);

    if (CHANNELS < 1)        begin : g_bad_channels $error("CHANNELS must be >= 1"); end
    if (SYNC_STAGES < 2)     begin : g_bad_sync     $error("SYNC_STAGES must be >= 2"); end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce $error("DEBOUNCE_CYCLES must be >= 1"); end
    if (HOLD_CYCLES < 1)     begin : g_bad_hold     $error("HOLD_CYCLES must be >= 1"); end
    if (REPEAT_CYCLES < 1)   begin : g_bad_repeat   $error("REPEAT_CYCLES must be >= 1"); end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        input_cond_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .INVERT         (INVERT[i])
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .in          (in[i]),
            .repeat_en   (repeat_en[i]),
            .level       (level[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .long_press  (long_press[i]),
            .repeat_pulse(repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_r;
    logic [1:0] repeat_en;
    logic [1:0] level, rise, fall, long_press, repeat_pulse;

    int checks = 0;
    int errors = 0;

    logic lv [0:63];
    logic ri [0:63];
    logic fa [0:63];
    logic lp [0:63];
    logic rp [0:63];
    logic oth[0:63];

    input_conditioner #(
        .CHANNELS       (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3),
        .INVERT         (2'b10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_r),
        .repeat_en   (repeat_en),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{level, rise, fall, long_press, repeat_pulse};
    endfunction

    // Drive channel ch active so it is first sampled at edge 1; if rel > 0
    // the inactive value is first sampled at edge rel. Records edges 1..n.
    task automatic run(input int ch, input int n, input int rel);
        int o;
        o = 1 - ch;
        in_r[ch] = (ch == 1) ? 1'b0 : 1'b1;
        for (int e = 1; e <= n; e++) begin
            if (e == rel) in_r[ch] = (ch == 1) ? 1'b1 : 1'b0;
            tick();
            lv[e]  = level[ch];
            ri[e]  = rise[ch];
            fa[e]  = fall[ch];
            lp[e]  = long_press[ch];
            rp[e]  = repeat_pulse[ch];
            oth[e] = |{level[o], rise[o], fall[o], long_press[o], repeat_pulse[o]};
        end
    endtask

    function automatic int count_lp(input int a, input int b);
        int c = 0;
        for (int e = a; e <= b; e++) c += int'(lp[e]);
        return c;
    endfunction

    function automatic int count_rp(input int a, input int b);
        int c = 0;
        for (int e = a; e <= b; e++) c += int'(rp[e]);
        return c;
    endfunction

    function automatic logic any_oth(input int a, input int b);
        logic r = 1'b0;
        for (int e = a; e <= b; e++) r |= oth[e];
        return r;
    endfunction

    task automatic settle();
        in_r = 2'b10;
        repeat (20) tick();
    endtask

    initial begin
        logic acc;

        // Reset state, then idle after release (ch1 idle-high must not rise)
        rst = 1'b1; in_r = 2'b10; repeat_en = 2'b00;
        repeat (3) tick();
        check("reset_outputs", 32'(any_out()), 32'd0);
        rst = 1'b0;
        acc = 1'b0;
        repeat (12) begin tick(); acc |= any_out(); end
        check("idle_after_reset", 32'(acc), 32'd0);

        // Clean press on ch0
        run(0, 8, 0);
        check("press_level_e5", 32'(lv[5]), 32'd0);
        check("press_level_e6", 32'(lv[6]), 32'd1);
        check("press_rise_e6",  32'(ri[6]), 32'd1);
        check("press_rise_e7",  32'(ri[7]), 32'd0);
        check("press_level_e7", 32'(lv[7]), 32'd1);
        check("press_ch1_quiet", 32'(any_oth(1, 8)), 32'd0);
        settle();
        check("press_released", 32'(level), 32'd0);

        // Bounce rejection: 3 high / 2 low, five times
        acc = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_r[0] = 1'b1;
            repeat (3) begin tick(); acc |= level[0] | rise[0] | fall[0]; end
            in_r[0] = 1'b0;
            repeat (2) begin tick(); acc |= level[0] | rise[0] | fall[0]; end
        end
        repeat (8) begin tick(); acc |= level[0] | rise[0] | fall[0]; end
        check("bounce_rejected", 32'(acc), 32'd0);

        // Long press with auto-repeat, release sampled at edge 27
        repeat_en = 2'b01;
        run(0, 40, 27);
        check("lp_e15",        32'(lp[15]), 32'd0);
        check("lp_e16",        32'(lp[16]), 32'd1);
        check("lp_count",      32'(count_lp(1, 40)), 32'd1);
        check("rp_before_19",  32'(count_rp(1, 18)), 32'd0);
        check("rp_e19",        32'(rp[19]), 32'd1);
        check("rp_e20",        32'(rp[20]), 32'd0);
        check("rp_e22",        32'(rp[22]), 32'd1);
        check("rp_e25",        32'(rp[25]), 32'd1);
        check("rel_level_e31", 32'(lv[31]), 32'd1);
        check("rel_fall_e32",  32'(fa[32]), 32'd1);
        check("rel_level_e32", 32'(lv[32]), 32'd0);
        check("rp_after_fall", 32'(count_rp(32, 40)), 32'd0);
        repeat_en = 2'b00;
        settle();

        // Repeat disabled: hold 40 cycles
        run(0, 40, 0);
        check("norep_lp_e16",  32'(lp[16]), 32'd1);
        check("norep_lp_cnt",  32'(count_lp(1, 40)), 32'd1);
        check("norep_rp_cnt",  32'(count_rp(1, 40)), 32'd0);
        settle();

        // Active-low channel 1, release sampled at edge 10
        run(1, 20, 10);
        check("ch1_level_e5",  32'(lv[5]), 32'd0);
        check("ch1_rise_e6",   32'(ri[6]), 32'd1);
        check("ch1_level_e14", 32'(lv[14]), 32'd1);
        check("ch1_fall_e15",  32'(fa[15]), 32'd1);
        check("ch1_level_e15", 32'(lv[15]), 32'd0);
        check("ch1_ch0_quiet", 32'(any_oth(1, 20)), 32'd0);
        settle();

        // Reset mid-hold: rst asserted for edges 12..17 of a held press
        in_r[0] = 1'b1;
        repeat (11) tick();
        check("hold_level_e11", 32'(level[0]), 32'd1);
        rst = 1'b1;
        acc = 1'b0;
        repeat (6) begin tick(); acc |= any_out(); end
        check("rst_mid_hold", 32'(acc), 32'd0);
        rst = 1'b0;
        run(0, 20, 0);
        check("post_rst_lv_e5", 32'(lv[5]), 32'd0);
        check("post_rst_ri_e6", 32'(ri[6]), 32'd1);
        check("post_rst_lp_15", 32'(lp[15]), 32'd0);
        check("post_rst_lp_16", 32'(lp[16]), 32'd1);
        check("post_rst_ch1",   32'(any_oth(1, 20)), 32'd0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
